// File: rtl/conv3d_ctrl.sv
// Output-stationary 3D-convolution sequencer and MAC engine: walks f,i,j,d,m,n,
// issues one IFM/weight read per cycle and streams finished pixels over valid/ready.
module conv3d_ctrl #(
    parameter int WT_DIM = 5,
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               cfg_ifm_dim,
    input  logic [7:0]               cfg_ifm_depth,
    input  logic [7:0]               cfg_ofm_depth,
    output logic                     idle,
    output logic                     done,
    output logic                     rd_en,
    output logic [AWIDTH-1:0]        ifm_addr,
    output logic [AWIDTH-1:0]        wt_addr,
    input  logic signed [DWIDTH-1:0] ifm_rdata,
    input  logic signed [DWIDTH-1:0] wt_rdata,
    output logic                     ofm_valid,
    input  logic                     ofm_ready,
    output logic [AWIDTH-1:0]        ofm_addr,
    output logic signed [DWIDTH-1:0] ofm_data
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    localparam logic [7:0]  K_LAST = 8'(WT_DIM - 1);
    localparam logic [31:0] KK     = 32'(WT_DIM * WT_DIM);

    state_e state_q, state_d;

    logic [7:0]  dim_q, ifd_q, ofd_q, od_q, od_in;
    logic [31:0] dd_q, odod_q, ifdkk_q;

    logic [7:0] f_q, i_q, j_q, d_q, m_q, n_q;
    logic [7:0] f_d, i_d, j_d, d_d, m_d, n_d;

    logic                     vld_p1_q, first_p1_q, last_p1_q;
    logic [AWIDTH-1:0]        addr_p1_q;
    logic signed [DWIDTH-1:0] acc_q, acc_next;

    logic                     ofm_valid_q;
    logic [AWIDTH-1:0]        ofm_addr_q;
    logic signed [DWIDTH-1:0] ofm_data_q;

    logic stall, cfg_load, degenerate;
    logic last_n, last_m, last_d, last_j, last_i, last_f, final_term;
    logic first_term, pixel_last;
    logic [AWIDTH-1:0] ifm_addr_s, wt_addr_s, ofm_addr_s;

    // Product and sum both wrap to DWIDTH bits; the low half of a product is sign-agnostic.
    function automatic logic signed [DWIDTH-1:0] mac_wrap(
        input logic signed [DWIDTH-1:0] base,
        input logic signed [DWIDTH-1:0] a,
        input logic signed [DWIDTH-1:0] b
    );
        return base + a * b;
    endfunction

    assign stall      = ofm_valid_q && !ofm_ready;
    assign rd_en      = (state_q == S_RUN) && !stall;
    assign idle       = (state_q == S_IDLE);
    assign done       = (state_q == S_DONE);
    assign cfg_load   = (state_q == S_IDLE) && start;
    assign degenerate = (cfg_ifm_dim < 8'(WT_DIM)) || (cfg_ifm_depth == 8'd0) ||
                        (cfg_ofm_depth == 8'd0);
    assign od_in      = cfg_ifm_dim - K_LAST;

    assign last_n     = (n_q == K_LAST);
    assign last_m     = (m_q == K_LAST);
    assign last_d     = (d_q == ifd_q - 8'd1);
    assign last_j     = (j_q == od_q - 8'd1);
    assign last_i     = (i_q == od_q - 8'd1);
    assign last_f     = (f_q == ofd_q - 8'd1);
    assign pixel_last = last_n && last_m && last_d;
    assign final_term = pixel_last && last_j && last_i && last_f;
    assign first_term = (n_q == 8'd0) && (m_q == 8'd0) && (d_q == 8'd0);

    // Stage 0: addresses straight from the loop counters
    assign ifm_addr_s = AWIDTH'(32'(d_q) * dd_q + (32'(i_q) + 32'(m_q)) * 32'(dim_q)
                                + 32'(j_q) + 32'(n_q));
    assign wt_addr_s  = AWIDTH'(32'(f_q) * ifdkk_q + 32'(d_q) * KK
                                + 32'(m_q) * 32'(WT_DIM) + 32'(n_q));
    assign ofm_addr_s = AWIDTH'(32'(f_q) * odod_q + 32'(i_q) * 32'(od_q) + 32'(j_q));
    assign ifm_addr   = rd_en ? ifm_addr_s : '0;
    assign wt_addr    = rd_en ? wt_addr_s : '0;

    always_ff @(posedge clk) begin
        if (cfg_load) begin
            dim_q   <= cfg_ifm_dim;
            ifd_q   <= cfg_ifm_depth;
            ofd_q   <= cfg_ofm_depth;
            od_q    <= od_in;
            dd_q    <= 32'(cfg_ifm_dim) * 32'(cfg_ifm_dim);
            odod_q  <= 32'(od_in) * 32'(od_in);
            ifdkk_q <= 32'(cfg_ifm_depth) * KK;
        end
    end

    always_comb begin
        state_d = state_q;
        f_d = f_q; i_d = i_q; j_d = j_q;
        d_d = d_q; m_d = m_q; n_d = n_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    f_d = '0; i_d = '0; j_d = '0;
                    d_d = '0; m_d = '0; n_d = '0;
                    state_d = degenerate ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (rd_en) begin
                    if (final_term) state_d = S_DRAIN;
                    n_d = n_q + 8'd1;
                    if (last_n) begin
                        n_d = '0;
                        m_d = m_q + 8'd1;
                        if (last_m) begin
                            m_d = '0;
                            d_d = d_q + 8'd1;
                            if (last_d) begin
                                d_d = '0;
                                j_d = j_q + 8'd1;
                                if (last_j) begin
                                    j_d = '0;
                                    i_d = i_q + 8'd1;
                                    if (last_i) begin
                                        i_d = '0;
                                        f_d = f_q + 8'd1;
                                    end
                                end
                            end
                        end
                    end
                end
            end
            // The final term must have left stage 1 before the accepted pixel is the last one.
            S_DRAIN: begin
                if (ofm_valid_q && ofm_ready && !vld_p1_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            f_q <= '0; i_q <= '0; j_q <= '0;
            d_q <= '0; m_q <= '0; n_q <= '0;
        end else begin
            state_q <= state_d;
            f_q <= f_d; i_q <= i_d; j_q <= j_d;
            d_q <= d_d; m_q <= m_d; n_q <= n_d;
        end
    end

    // Stage 1: tags travel with the read; rdata arrives this cycle (or is held by the buffers)
    assign acc_next = mac_wrap(first_p1_q ? '0 : acc_q, ifm_rdata, wt_rdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q   <= 1'b0;
            first_p1_q <= 1'b0;
            last_p1_q  <= 1'b0;
            addr_p1_q  <= '0;
            acc_q      <= '0;
        end else if (!stall) begin
            vld_p1_q   <= rd_en;
            first_p1_q <= first_term;
            last_p1_q  <= pixel_last;
            addr_p1_q  <= ofm_addr_s;
            if (vld_p1_q) acc_q <= acc_next;
        end
    end

    // Output register: a new pixel may replace an accepted one in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ofm_valid_q <= 1'b0;
            ofm_addr_q  <= '0;
            ofm_data_q  <= '0;
        end else if (!stall) begin
            if (vld_p1_q && last_p1_q) begin
                ofm_valid_q <= 1'b1;
                ofm_addr_q  <= addr_p1_q;
                ofm_data_q  <= acc_next;
            end else if (ofm_valid_q && ofm_ready) begin
                ofm_valid_q <= 1'b0;
            end
        end
    end

    assign ofm_valid = ofm_valid_q;
    assign ofm_addr  = ofm_addr_q;
    assign ofm_data  = ofm_data_q;

endmodule

// File: tb/tb_conv3d_ctrl.sv
// Randomized bench for conv3d_ctrl: synchronous buffer models plus a plain-loop
// convolution reference that predicts the read stream, pixels and timing.
module tb_conv3d_ctrl;
    localparam int K = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, ofm_ready;
    logic [7:0]  cfg_ifm_dim, cfg_ifm_depth, cfg_ofm_depth;
    logic        idle, done, rd_en, ofm_valid;
    logic [15:0] ifm_addr, wt_addr, ofm_addr;
    logic signed [31:0] ifm_rdata = '0;
    logic signed [31:0] wt_rdata  = '0;
    logic signed [31:0] ofm_data;

    int ifm_mem [65536];
    int wt_mem  [65536];
    int n_checks = 0;
    int n_pass   = 0;

    conv3d_ctrl #(.WT_DIM(K), .DWIDTH(32), .AWIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_ifm_dim(cfg_ifm_dim), .cfg_ifm_depth(cfg_ifm_depth), .cfg_ofm_depth(cfg_ofm_depth),
        .idle(idle), .done(done), .rd_en(rd_en),
        .ifm_addr(ifm_addr), .wt_addr(wt_addr),
        .ifm_rdata(ifm_rdata), .wt_rdata(wt_rdata),
        .ofm_valid(ofm_valid), .ofm_ready(ofm_ready),
        .ofm_addr(ofm_addr), .ofm_data(ofm_data)
    );

    // Synchronous buffers: data the cycle after rd_en, held otherwise
    always @(posedge clk) begin
        if (rd_en) begin
            ifm_rdata <= ifm_mem[ifm_addr];
            wt_rdata  <= wt_mem[wt_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic fill_mem(input int dim, input int ifd, input int ofd, input bit basic);
        for (int a = 0; a < dim * dim * ifd; a++)
            ifm_mem[a] = basic ? (a - 128) : int'($urandom);
        for (int f = 0; f < ofd; f++)
            for (int d = 0; d < ifd; d++)
                for (int m = 0; m < K; m++)
                    for (int n = 0; n < K; n++) begin
                        int idx;
                        idx = ((f * ifd + d) * K + m) * K + n;
                        if (basic) wt_mem[idx] = (n % 2 == 0) ? -(m + n) : (m + n);
                        else       wt_mem[idx] = int'($urandom);
                    end
    endtask

    task automatic run_layer(input string tag, input int dim, input int ifd, input int ofd,
                             input int low_pct, input int busy_cyc);
        int od, T, npix, cyc, budget, stalls, rd_cnt, first_rd, last_rd, vcnt, first_v, done_cyc;
        bit degen, stl, prev_stall;
        logic [15:0] prev_addr;
        logic [31:0] prev_data;
        logic [31:0] exp_rd[$];
        logic [15:0] exp_oa[$];
        int          exp_od[$];

        degen = (dim < K) || (ifd == 0) || (ofd == 0);
        od    = dim - K + 1;
        T     = degen ? 0 : ofd * od * od * ifd * K * K;
        if (!degen) begin
            for (int f = 0; f < ofd; f++)
                for (int i = 0; i < od; i++)
                    for (int j = 0; j < od; j++) begin
                        int acc;
                        acc = 0;
                        for (int d = 0; d < ifd; d++)
                            for (int m = 0; m < K; m++)
                                for (int n = 0; n < K; n++) begin
                                    int ia, wa;
                                    ia = d * dim * dim + (i + m) * dim + (j + n);
                                    wa = ((f * ifd + d) * K + m) * K + n;
                                    acc += ifm_mem[ia] * wt_mem[wa];
                                    exp_rd.push_back({ia[15:0], wa[15:0]});
                                end
                        exp_oa.push_back(16'((f * od + i) * od + j));
                        exp_od.push_back(acc);
                    end
        end
        npix = exp_oa.size();

        @(posedge clk); #1;
        cfg_ifm_dim = 8'(dim); cfg_ifm_depth = 8'(ifd); cfg_ofm_depth = 8'(ofd);
        start = 1'b1; ofm_ready = 1'b1;
        cyc = 0; stalls = 0; rd_cnt = 0; first_rd = -1; last_rd = -1;
        vcnt = 0; first_v = -1; done_cyc = -1; prev_stall = 1'b0;
        prev_addr = '0; prev_data = '0;
        budget = 3 * T + 100;

        while (done_cyc < 0 && cyc < budget) begin
            @(posedge clk); cyc++; #1;
            start = 1'b0;
            cfg_ifm_dim = 8'($urandom); cfg_ifm_depth = 8'($urandom); cfg_ofm_depth = 8'($urandom);
            if (cyc == busy_cyc) begin
                start = 1'b1;
                cfg_ifm_dim = 8'(dim + 1); cfg_ifm_depth = 8'(ifd + 1); cfg_ofm_depth = 8'(ofd + 2);
            end
            ofm_ready = ($urandom_range(99) >= low_pct);
            #1;
            stl = ofm_valid && !ofm_ready;
            if (prev_stall) begin
                chk({tag, "_hold_valid"}, 32'(ofm_valid), 32'd1);
                chk({tag, "_hold_addr"}, 32'(ofm_addr), 32'(prev_addr));
                chk({tag, "_hold_data"}, ofm_data, prev_data);
            end
            if (stl) begin
                stalls++;
                chk({tag, "_rd_in_stall"}, 32'(rd_en), 32'd0);
            end
            if (rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                if (exp_rd.size() == 0) chk({tag, "_extra_read"}, 32'd1, 32'd0);
                else chk({tag, "_rd_addr"}, {ifm_addr, wt_addr}, exp_rd.pop_front());
            end
            if (ofm_valid) begin
                vcnt++;
                if (first_v < 0) first_v = cyc;
                if (ofm_ready) begin
                    if (exp_oa.size() == 0) chk({tag, "_extra_pixel"}, 32'd1, 32'd0);
                    else begin
                        chk({tag, "_ofm_addr"}, 32'(ofm_addr), 32'(exp_oa.pop_front()));
                        chk({tag, "_ofm_data"}, ofm_data, exp_od.pop_front());
                    end
                end
            end
            if (done) done_cyc = cyc;
            prev_stall = stl; prev_addr = ofm_addr; prev_data = ofm_data;
        end

        if (done_cyc < 0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        chk({tag, "_done_cycle"}, done_cyc, degen ? 1 : T + 3 + stalls);
        chk({tag, "_rd_count"}, rd_cnt, T);
        chk({tag, "_pixels_left"}, exp_oa.size(), 0);
        if (low_pct == 0) begin
            chk({tag, "_first_rd"}, first_rd, degen ? -1 : 1);
            chk({tag, "_last_rd"}, last_rd, degen ? -1 : T);
            chk({tag, "_valid_cycles"}, vcnt, npix);
            if (npix > 0) chk({tag, "_first_valid"}, first_v, ifd * K * K + 2);
        end
        @(posedge clk); #2;
        chk({tag, "_after_done"}, {28'd0, done, idle, rd_en, ofm_valid}, 32'b0100);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ofm_ready = 1'b0;
        cfg_ifm_dim = '0; cfg_ifm_depth = '0; cfg_ofm_depth = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_ctrl", {28'd0, idle, done, rd_en, ofm_valid}, 32'b1000);
        chk("reset_addr", {ifm_addr, wt_addr}, 32'd0);
        chk("reset_ofm_addr", 32'(ofm_addr), 32'd0);
        chk("reset_ofm_data", ofm_data, 32'd0);

        fill_mem(5, 1, 1, 1'b1);
        run_layer("basic", 5, 1, 1, 0, -1);

        fill_mem(10, 2, 2, 1'b0);
        run_layer("layer", 10, 2, 2, 0, -1);
        run_layer("backpressure", 10, 2, 2, 30, -1);

        for (int r = 0; r < 3; r++) begin
            int dm, fd, od_;
            dm  = $urandom_range(9, 5);
            fd  = $urandom_range(3, 1);
            od_ = $urandom_range(3, 1);
            fill_mem(dm, fd, od_, 1'b0);
            run_layer("rand", dm, fd, od_, (r == 1) ? 0 : 25, -1);
        end

        run_layer("degen_dim", 4, 2, 2, 0, -1);
        run_layer("degen_ifd", 8, 0, 2, 0, -1);
        run_layer("degen_ofd", 8, 1, 0, 0, -1);

        fill_mem(7, 1, 2, 1'b0);
        run_layer("busy_start", 7, 1, 2, 0, 10);

        // Reset with a stalled pixel pending in the middle of a layer
        fill_mem(6, 1, 1, 1'b0);
        @(posedge clk); #1;
        cfg_ifm_dim = 8'd6; cfg_ifm_depth = 8'd1; cfg_ofm_depth = 8'd1;
        start = 1'b1; ofm_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #2;
        chk("rstmid_pending", 32'(ofm_valid), 32'd1);
        chk("rstmid_busy", 32'(idle), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstmid_after", {28'd0, idle, done, rd_en, ofm_valid}, 32'b1000);

        fill_mem(5, 1, 1, 1'b1);
        run_layer("rst_basic", 5, 1, 1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
